// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the program counter, presents it to the
//   combinational instruction ROM and captures the returned word into the
//   IF/ID pipeline register. Supports stall, taken-branch redirect (with a
//   single flush bubble) and halts permanently on a misaligned or
//   out-of-range PC until reset.
//
// Ports
//   clk            in   1   clock, all state updates on posedge
//   reset          in   1   synchronous active-high reset
//   stall          in   1   hold PC and IF/ID
//   branch_taken   in   1   redirect request from execute
//   branch_target  in   64  redirect byte address
//   pc_address     out  64  current PC (ROM address)
//   imem_instr     in   32  ROM data for pc_address, same cycle
//   if_id_pc       out  64  PC of the instruction in IF/ID
//   if_id_instr    out  32  instruction in IF/ID
//   if_id_valid    out  1   IF/ID holds a real instruction
//   fetch_fault    out  1   sticky halt-on-bad-PC flag
//   fetch_count    out  32  instructions captured into IF/ID (wrapping)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [31:0] NOP_WORD = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] pc_address,
  input  logic [31:0] imem_instr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  // Range check done one bit wider so a PC near the top of the address
  // space cannot wrap back into the valid window.
  logic [64:0] pc_end;
  logic        bad_pc;

  assign pc_end = {1'b0, pc_q} + 65'd3;
  assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_end >= 65'(MEM_SIZE));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fault_d       = fault_q;
    count_d       = count_q;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall; the target is validated next cycle.
          pc_d          = branch_target;
          if_id_pc_d    = 64'd0;
          if_id_instr_d = NOP_WORD;
          if_id_valid_d = 1'b0;
        end else if (bad_pc) begin
          state_d       = ST_HALT;
          fault_d       = 1'b1;
          if_id_pc_d    = 64'd0;
          if_id_instr_d = NOP_WORD;
          if_id_valid_d = 1'b0;
        end else if (!stall) begin
          if_id_pc_d    = pc_q;
          if_id_instr_d = imem_instr;
          if_id_valid_d = 1'b1;
          pc_d          = pc_q + 64'd4;
          count_d       = count_q + 32'd1;
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT; keep IF/ID drained.
        fault_d       = 1'b1;
        if_id_pc_d    = 64'd0;
        if_id_instr_d = NOP_WORD;
        if_id_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 64'd0;
      if_id_instr_q <= NOP_WORD;
      if_id_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      count_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fault_q       <= fault_d;
      count_q       <= count_d;
    end
  end

  assign pc_address  = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] pc_address;
  logic [31:0] imem_instr;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .RESET_PC(64'd0),
    .MEM_SIZE(1024),
    .NOP_WORD(32'hD503201F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc_address   (pc_address),
    .imem_instr   (imem_instr),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_fault  (fetch_fault),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  // Hand-defined ROM contents: word at byte address A is A5000000 + A/4.
  function automatic logic [31:0] w(input logic [63:0] addr);
    return 32'hA500_0000 + addr[33:2];
  endfunction

  always_comb begin
    if (pc_address < 64'd1024) imem_instr = w(pc_address);
    else                       imem_instr = 32'hxxxx_xxxx;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_if(input string tag, input logic [63:0] epc, input logic [31:0] ein,
                        input logic ev, input logic [31:0] ecnt);
    chk({tag, ".if_pc"}, if_id_pc, epc);
    chk({tag, ".instr"}, 64'(if_id_instr), 64'(ein));
    chk({tag, ".valid"}, 64'(if_id_valid), 64'(ev));
    chk({tag, ".count"}, 64'(fetch_count), 64'(ecnt));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    #2;
    step();
    // Reset state
    chk("rst.pc", pc_address, 64'd0);
    chk("rst.fault", 64'(fetch_fault), 64'd0);
    chk_if("rst", 64'd0, NOP, 1'b0, 32'd0);
    reset = 1'b0;

    // 1: free run, capture one cycle after address presented
    for (int k = 1; k <= 2; k++) begin
      step();
      chk("run.pc", pc_address, 64'(4 * k));
      chk_if("run", 64'(4 * (k - 1)), w(64'(4 * (k - 1))), 1'b1, 32'(k));
    end

    // 2: stall at PC=8 for three cycles
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall.pc", pc_address, 64'd8);
      chk_if("stall", 64'd4, w(64'd4), 1'b1, 32'd2);
    end
    stall = 1'b0;
    step();
    chk("unstall.pc", pc_address, 64'd12);
    chk_if("unstall", 64'd8, w(64'd8), 1'b1, 32'd3);

    // 3: branch overrides stall at PC=12
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd64;
    step();
    chk("br.pc", pc_address, 64'd64);
    chk_if("br", 64'd0, NOP, 1'b0, 32'd3);
    stall = 1'b0; branch_taken = 1'b0;
    step();
    chk("br2.pc", pc_address, 64'd68);
    chk_if("br2", 64'd64, w(64'd64), 1'b1, 32'd4);

    // 4: run to the last word, then fault at 1024
    for (int i = 0; i < 300 && pc_address != 64'd1020; i++) step();
    chk("reach1020", pc_address, 64'd1020);
    chk("cnt1020", 64'(fetch_count), 64'd242);
    step();
    chk("last.pc", pc_address, 64'd1024);
    chk_if("last", 64'd1020, w(64'd1020), 1'b1, 32'd243);
    chk("last.fault", 64'(fetch_fault), 64'd0);
    step();
    chk("oor.fault", 64'(fetch_fault), 64'd1);
    chk("oor.pc", pc_address, 64'd1024);
    chk_if("oor", 64'd0, NOP, 1'b0, 32'd243);
    step();
    chk("oor2.pc", pc_address, 64'd1024);
    chk("oor2.fault", 64'(fetch_fault), 64'd1);

    // 5: misaligned target, branch ignored in HALT, reset clears
    reset = 1'b1;
    step();
    reset = 1'b0; branch_taken = 1'b1; branch_target = 64'd6;
    step();
    chk("mis.pc", pc_address, 64'd6);
    chk("mis.fault0", 64'(fetch_fault), 64'd0);
    branch_taken = 1'b0;
    step();
    chk("mis.fault1", 64'(fetch_fault), 64'd1);
    chk("mis.pc2", pc_address, 64'd6);
    chk_if("mis", 64'd0, NOP, 1'b0, 32'd0);
    branch_taken = 1'b1; branch_target = 64'd64;
    step();
    branch_taken = 1'b0;
    chk("halt.pc", pc_address, 64'd6);
    chk("halt.fault", 64'(fetch_fault), 64'd1);
    chk("halt.valid", 64'(if_id_valid), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2.pc", pc_address, 64'd0);
    chk("rst2.fault", 64'(fetch_fault), 64'd0);
    chk("rst2.count", 64'(fetch_count), 64'd0);

    // 6: reset mid-stream at PC=40 with a branch pending
    for (int k = 0; k < 10; k++) step();
    chk("pc40", pc_address, 64'd40);
    chk("cnt10", 64'(fetch_count), 64'd10);
    reset = 1'b1; branch_taken = 1'b1; branch_target = 64'd64;
    step();
    reset = 1'b0; branch_taken = 1'b0;
    chk("rst3.pc", pc_address, 64'd0);
    chk_if("rst3", 64'd0, NOP, 1'b0, 32'd0);

    // Aligned target at the very top of the address space must fault
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step();
    chk("top.fault", 64'(fetch_fault), 64'd1);
    chk("top.pc", pc_address, 64'hFFFF_FFFF_FFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
